// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter: opcodes,
// opcode width and result-slot states.
package logic_unit_arbiter_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5
   } op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the two sequencers, the arbiter and the
// result consumer; master drives requests and resp_ready, slave is the arbiter.
interface logic_unit_arbiter_if
   import logic_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OP_W-1:0]  req0_op;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OP_W-1:0]  req1_op;

   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_id;
   logic             resp_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  resp_valid, resp_data, resp_id, resp_err,
      output resp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output resp_valid, resp_data, resp_id, resp_err,
      input  resp_ready
   );

endinterface

// File: rtl/logic_op_unit.sv
// Combinational bitwise-logic datapath; output forced to zero when not enabled,
// illegal flags opcodes 6 and 7 (which also yield zero).
module logic_op_unit
   import logic_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic             illegal
);

   always_comb begin
      y       = '0;
      illegal = 1'b0;
      if (en) begin
         case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between two requesters, with a
// single registered result slot tagged by requester id.
module logic_unit_arbiter
   import logic_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   logic_unit_arbiter_if.slave  bus
);

   slot_state_e      state_q;
   slot_state_e      state_d;
   logic             ptr_q;
   logic             slot_free;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             gnt_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [OP_W-1:0]  op_sel;
   logic [WIDTH-1:0] op_y;
   logic             op_illegal;
   logic [WIDTH-1:0] data_q;
   logic             id_q;
   logic             err_q;

   // Grants depend only on valids, pointer and slot state, never on the other ready.
   always_comb begin
      slot_free = (state_q == ST_EMPTY) || bus.resp_ready;
      grant0    = rst_n && slot_free && bus.req0_valid && (!bus.req1_valid || !ptr_q);
      grant1    = rst_n && slot_free && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
      accept    = grant0 || grant1;
      gnt_id    = grant1;
      op_a      = grant1 ? bus.req1_a  : bus.req0_a;
      op_b      = grant1 ? bus.req1_b  : bus.req0_b;
      op_sel    = grant1 ? bus.req1_op : bus.req0_op;
   end

   logic_op_unit #(
      .WIDTH (WIDTH)
   ) u_op (
      .a       (op_a),
      .b       (op_b),
      .op      (op_sel),
      .en      (accept),
      .y       (op_y),
      .illegal (op_illegal)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (bus.resp_ready && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         ptr_q   <= 1'b0;
         data_q  <= '0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q <= op_y;
            id_q   <= gnt_id;
            err_q  <= op_illegal;
            ptr_q  <= ~gnt_id;
         end
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.resp_valid = (state_q == ST_FULL);
   assign bus.resp_data  = data_q;
   assign bus.resp_id    = id_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed scenarios plus randomized traffic for logic_unit_arbiter, checked
// against a transaction-level model of the arbiter and result slot.
module tb_logic_unit_arbiter;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

   logic_unit_arbiter #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one result slot plus the priority owner.
   bit         m_valid = 1'b0;
   bit [7:0]   m_data  = '0;
   bit         m_id    = 1'b0;
   bit         m_err   = 1'b0;
   bit         m_prio  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit [7:0] ref_result(input bit [2:0] op, input bit [7:0] a, input bit [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         default: return 8'h00;
      endcase
   endfunction

   // Called at a falling edge with inputs already driven; checks, clocks once,
   // advances the model and returns at the next falling edge.
   task automatic tick(output bit g0, output bit g1);
      bit free;
      bit [7:0] a, b;
      bit [2:0] op;
      #1;
      free = !m_valid || bus.resp_ready;
      g0 = 1'b0;
      g1 = 1'b0;
      if (rst_n && free) begin
         if (bus.req0_valid && bus.req1_valid) begin
            g0 = (m_prio == 1'b0);
            g1 = (m_prio == 1'b1);
         end else begin
            g0 = bus.req0_valid;
            g1 = bus.req1_valid;
         end
      end
      check_val("req0_ready", bus.req0_ready, g0);
      check_val("req1_ready", bus.req1_ready, g1);
      check_val("resp_valid", bus.resp_valid, m_valid);
      if (m_valid) begin
         check_val("resp_data", bus.resp_data, m_data);
         check_val("resp_id",   bus.resp_id,   m_id);
         check_val("resp_err",  bus.resp_err,  m_err);
      end
      a  = g1 ? bus.req1_a  : bus.req0_a;
      b  = g1 ? bus.req1_b  : bus.req0_b;
      op = g1 ? bus.req1_op : bus.req0_op;
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_id    = 1'b0;
         m_err   = 1'b0;
         m_prio  = 1'b0;
      end else if (g0 || g1) begin
         m_valid = 1'b1;
         m_data  = ref_result(op, a, b);
         m_id    = g1;
         m_err   = (op > 3'd5);
         m_prio  = !g1;
      end else if (bus.resp_ready) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v0, input bit [7:0] a0, input bit [7:0] b0, input bit [2:0] op0,
                        input bit v1, input bit [7:0] a1, input bit [7:0] b1, input bit [2:0] op1,
                        input bit rr);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
      bus.resp_ready = rr;
   endtask

   initial begin
      bit g0, g1, prev_g1;
      rst_n = 1'b0;
      drive(1, 8'h12, 8'h34, 3'd0, 1, 8'h56, 8'h78, 3'd1, 1);
      @(posedge clk);
      @(negedge clk);

      // Reset held with both requesters valid
      tick(g0, g1);
      tick(g0, g1);
      check_val("rst_valid", bus.resp_valid, 0);
      check_val("rst_data",  bus.resp_data, 0);
      check_val("rst_id",    bus.resp_id, 0);
      check_val("rst_err",   bus.resp_err, 0);

      // Single request from requester 0
      rst_n = 1'b1;
      drive(1, 8'hF0, 8'h3C, 3'd2, 0, 8'h00, 8'h00, 3'd0, 1);
      tick(g0, g1);
      drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1);
      check_val("t2_data", bus.resp_data, 8'hCC);
      check_val("t2_id",   bus.resp_id, 0);
      check_val("t2_err",  bus.resp_err, 0);
      tick(g0, g1);

      // Continuous contention
      drive(1, 8'hAA, 8'h0F, 3'd0, 1, 8'h11, 8'h22, 3'd4, 1);
      prev_g1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(g0, g1);
         check_val("t3_onehot", {31'd0, g0 ^ g1}, 1);
         if (i > 0) check_val("t3_alt", {31'd0, g1}, {31'd0, !prev_g1});
         check_val("t3_id",   bus.resp_id, g1);
         check_val("t3_data", bus.resp_data, g1 ? 8'hCC : 8'h0A);
         prev_g1 = g1;
      end

      // Backpressure with slot full
      drive(0, 8'h00, 8'h00, 3'd0, 1, 8'h55, 8'h0F, 3'd1, 0);
      tick(g0, g1);
      tick(g0, g1);
      bus.resp_ready = 1'b1;
      tick(g0, g1);
      check_val("t4_data", bus.resp_data, 8'h5F);
      check_val("t4_id",   bus.resp_id, 1);

      // Illegal opcode from requester 1
      drive(0, 8'h00, 8'h00, 3'd0, 1, 8'hFF, 8'hFF, 3'd7, 1);
      tick(g0, g1);
      check_val("t5_data", bus.resp_data, 8'h00);
      check_val("t5_err",  bus.resp_err, 1);
      check_val("t5_id",   bus.resp_id, 1);

      // Reset while full with requester 0 valid
      drive(1, 8'h0F, 8'hFF, 3'd0, 0, 8'h00, 8'h00, 3'd0, 0);
      tick(g0, g1);
      tick(g0, g1);
      rst_n = 1'b0;
      tick(g0, g1);
      check_val("t6_valid", bus.resp_valid, 0);
      rst_n = 1'b1;
      drive(1, 8'h0F, 8'hFF, 3'd0, 1, 8'hF0, 8'hFF, 3'd1, 1);
      tick(g0, g1);
      check_val("t6_id", bus.resp_id, 0);
      check_val("t6_data", bus.resp_data, 8'h0F);

      // Randomized traffic obeying the hold-while-waiting rule
      for (int n = 0; n < 1500; n++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         if (!(bus.req0_valid && !g0)) begin
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req0_a     = 8'($urandom);
            bus.req0_b     = 8'($urandom);
            bus.req0_op    = 3'($urandom_range(0, 7));
         end
         if (!(bus.req1_valid && !g1)) begin
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req1_a     = 8'($urandom);
            bus.req1_b     = 8'($urandom);
            bus.req1_op    = 3'($urandom_range(0, 7));
         end
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         tick(g0, g1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
